raster_frame_reader: RTL and testbench

- Reads one W×H frame of pixels out of the frame-buffer SRAM in raster order and presents it as a valid/ready pixel stream to the FAST corner pipeline.
- It is the read-side counterpart of the frame writer. It uses nested column/row counters (flex-counter style, rollover at IMG_W-1 / IMG_H-1) and a 2-entry output buffer that absorbs the fixed 1-cycle SRAM read latency and downstream backpressure.

---
 rtl/isp_pkg.sv | 23 ++
 rtl/raster_frame_reader_flex_counter.sv | 42 ++++
 rtl/raster_frame_reader.sv | 159 +++++++++++++++
 tb/tb_raster_frame_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions.
// Contents:
//   rd_state_t - frame reader FSM states
//   pixel_t    - default-width pixel type (8 bits)
//   coord_w()  - width of a coordinate counter for a given image dimension
package isp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int unsigned PIX_W_DEF = 8;
  typedef logic [PIX_W_DEF-1:0] pixel_t;

  // Coordinate width for a dimension of n pixels; at least one bit.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_frame_reader_flex_counter.sv
// Flex counter: counts enabled cycles and rolls over to zero after
// reaching rollover_val. clear has priority over count_enable.
// Ports:
//   clk, n_rst           - clock, asynchronous active-low reset
//   clear                - synchronous return to zero
//   count_enable         - advance by one this cycle
//   rollover_val [W-1:0] - last value before wrapping to zero
//   count_out    [W-1:0] - current count
//   rollover_flag        - count_out equals rollover_val
module flex_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out,
  output logic         rollover_flag
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out     = count_q;
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/raster_frame_reader.sv
// Raster frame reader: reads one IMG_W x IMG_H frame from the frame-buffer
// SRAM in raster order and streams it out as pixels with coordinates and
// row/frame markers.
// Ports:
//   clk, n_rst        - clock, asynchronous active-low reset
//   start, base_addr  - frame request (honoured only when idle) and start address
//   mem_ren, mem_addr - SRAM read request; mem_rdata returns one cycle later
//   pix_*             - output pixel stream with coordinates and sol/eol/eof
//   busy, done        - frame in progress / one-cycle completion pulse
//   dbg_state         - current FSM state for observation
// Handshake: a pixel transfers on a cycle where pix_valid and pix_ready are
// both high; while pix_valid is high and pix_ready low, every pix_* output
// holds its value, and pix_valid never drops before the transfer.
module raster_frame_reader
  import isp_pkg::*;
#(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned XW    = coord_w(IMG_W),
  localparam int unsigned YW    = coord_w(IMG_H)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done,
  output rd_state_t         dbg_state
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  rd_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic [XW-1:0]     inflight_x_q;
  logic [YW-1:0]     inflight_y_q;
  logic [PIX_W-1:0]  buf_data_q [2];
  logic [XW-1:0]     buf_x_q    [2];
  logic [YW-1:0]     buf_y_q    [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        buf_count_q;

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          col_last, row_last;
  logic          accept, pop, issue, last_issue;
  logic [2:0]    occupancy;

  assign accept    = (state_q == IDLE) && start;
  assign pix_valid = (buf_count_q != 2'd0);
  assign pop       = pix_valid && pix_ready;

  // Entries that will hold data after this cycle: buffered + in flight - leaving.
  assign occupancy = {1'b0, buf_count_q} + {2'b0, inflight_q} - {2'b0, pop};

  // The first read goes out in the start cycle itself so the first pixel
  // is presented two cycles after start.
  assign issue      = accept || ((state_q == ISSUE) && (occupancy < 3'd2));
  assign last_issue = (state_q == ISSUE) && issue && col_last && row_last;

  assign mem_ren  = issue;
  assign mem_addr = accept ? base_addr : addr_q;

  flex_counter #(.W(XW)) u_col (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_q == DONE),
    .count_enable (issue),
    .rollover_val (X_LAST),
    .count_out    (col),
    .rollover_flag(col_last)
  );

  flex_counter #(.W(YW)) u_row (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (state_q == DONE),
    .count_enable (issue && col_last),
    .rollover_val (Y_LAST),
    .count_out    (row),
    .rollover_flag(row_last)
  );

  // Control FSM, address register and in-flight slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      inflight_x_q <= '0;
      inflight_y_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_x_q <= col;
        inflight_y_q <= row;
        addr_q       <= mem_addr + 1'b1;
      end
      case (state_q)
        IDLE:    if (start) state_q <= ISSUE;
        ISSUE:   if (last_issue) state_q <= DRAIN;
        DRAIN:   if (pop && pix_eof) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry output buffer; returning read data is written unconditionally
  // because the issue rule guarantees a free slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_x_q[i]    <= '0;
        buf_y_q[i]    <= '0;
      end
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      buf_count_q <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= mem_rdata;
        buf_x_q[wr_ptr_q]    <= inflight_x_q;
        buf_y_q[wr_ptr_q]    <= inflight_y_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      buf_count_q <= buf_count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign pix_data  = buf_data_q[rd_ptr_q];
  assign pix_x     = buf_x_q[rd_ptr_q];
  assign pix_y     = buf_y_q[rd_ptr_q];
  // Flags are qualified by pix_valid so they read 0 while the buffer is empty.
  assign pix_sol   = pix_valid && (pix_x == '0);
  assign pix_eol   = pix_valid && (pix_x == X_LAST);
  assign pix_eof   = pix_eol && (pix_y == Y_LAST);
  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_raster_frame_reader.sv
module tb_raster_frame_reader;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_data;
  logic [1:0]  pix_x, pix_y;
  logic        pix_sol, pix_eol, pix_eof, busy, done;
  isp_pkg::rd_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected pixel word: {data, x, y, sol, eol, eof}
  logic [14:0] exp_q[$];
  logic [15:0] exp_addr_q[$];

  int   ready_mode = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: stalled, 3: random
  int   ph = 0;
  int   cyc = 0, start_cyc = 0;
  int   reads = 0, pops = 0;
  bit   mon_en = 0, first_pending = 0, expect_done = 0, stall_prev = 0;
  logic [14:0] prev_word, mw;
  logic [16:0] ea;
  logic [15:0] ep;

  raster_frame_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(8), .ADDR_W(16)
  ) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sol(pix_sol), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / SRAM model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_ren) mem_rdata <= mem_addr[7:0];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: begin pix_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
      2: pix_ready = 1'b0;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic start_frame(input logic [15:0] base);
    logic [15:0] a;
    logic [1:0]  x, y;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    start_cyc = cyc;
    first_pending = 1;
    for (int i = 0; i < NPIX; i++) begin
      a = base + 16'(i);
      x = 2'(i % IMG_W);
      y = 2'(i / IMG_W);
      exp_addr_q.push_back(a);
      exp_q.push_back({a[7:0], x, y, x == 2'd0, x == 2'(IMG_W - 1), i == NPIX - 1});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit full_rate);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    check("frame_done", 32'(seen), 32'd1);
    if (seen && full_rate) check("done_cycle", 32'(cyc - start_cyc), 32'(NPIX + 2));
    check("pix_queue_empty", 32'(exp_q.size()), 32'd0);
    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && n_rst) begin
      mw = {pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_eof};
      check("done", 32'(done), 32'(expect_done));
      if (done) check("busy_at_done", 32'(busy), 32'd0);
      expect_done = 0;
      if (stall_prev) check("stall_hold", {16'd0, pix_valid, mw}, {16'd0, 1'b1, prev_word});
      stall_prev = pix_valid && !pix_ready;
      prev_word  = mw;
      if (pix_valid && first_pending) begin
        check("first_latency", 32'(cyc - start_cyc), 32'd2);
        first_pending = 0;
      end
      if (mem_ren) begin
        check("ren_room", 32'((reads - pops - int'(pix_valid && pix_ready)) < 2), 32'd1);
        ea = (exp_addr_q.size() != 0) ? {1'b1, exp_addr_q.pop_front()} : 17'd0;
        check("rd_addr", {15'd0, 1'b1, mem_addr}, {15'd0, ea});
        reads++;
      end
      if (pix_valid && pix_ready) begin
        ep = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 16'd0;
        check("pixel", {16'd0, 1'b1, mw}, {16'd0, ep});
        pops++;
        if (pix_eof) expect_done = 1;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int r0, p0;
    bit found;

    repeat (3) @(posedge clk); #1;
    check("rst_mem", {15'd0, mem_ren, mem_addr}, 32'd0);
    check("rst_pix", {14'd0, pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_eof, busy, done}, 32'd0);
    n_rst = 1'b1;
    mon_en = 1;

    // Full-rate frame
    ready_mode = 0;
    start_frame(16'h0010);
    wait_done(100, 1);

    // Backpressure pattern 1,0,0,1
    ph = 0;
    ready_mode = 1;
    start_frame(16'h0010);
    wait_done(200, 0);

    // Held off for 10 cycles: only two reads may go out
    ready_mode = 2;
    r0 = reads;
    start_frame(16'h0010);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    check("stall_reads", 32'(reads - r0), 32'd2);
    check("stall_valid", 32'(pix_valid), 32'd1);
    check("stall_data", 32'(pix_data), 32'h10);
    ready_mode = 0;
    wait_done(100, 0);

    // Address wrap, start mid-frame and in DONE ignored
    ready_mode = 0;
    start_frame(16'hFFFA);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #1;
      if (pix_valid && pix_ready && pix_eof) found = 1;
    end
    check("eof_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    check("state_done", 32'(dbg_state), 32'(isp_pkg::DONE));
    start = 1'b1; base_addr = 16'h5555;
    @(posedge clk); #1;
    start = 1'b0;
    check("state_idle", 32'(dbg_state), 32'(isp_pkg::IDLE));
    repeat (4) @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure
    ready_mode = 3;
    start_frame(16'h0100);
    wait_done(300, 0);

    // Reset after five pixels, then a clean frame
    ready_mode = 0;
    p0 = pops;
    start_frame(16'h0040);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk); #2;
      if (pops - p0 >= 5) found = 1;
    end
    check("five_pixels", 32'(found), 32'd1);
    n_rst = 1'b0;
    #1;
    check("abort_mem", {15'd0, mem_ren, mem_addr}, 32'd0);
    check("abort_pix", {14'd0, pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_eof, busy, done}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    expect_done = 0;
    stall_prev = 0;
    first_pending = 0;
    reads = 0;
    pops = 0;
    repeat (2) @(posedge clk); #1;
    n_rst = 1'b1;
    start_frame(16'h0000);
    wait_done(100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
